pb_key_decoder: RTL and testbench

Pushbutton front end for the calculator datapath. Synchronizes and debounces the 10 raw breakout-board pushbutton inputs and converts each clean single-key press into a 4-bit key code. Queues the codes in a 4-entry FIFO that the calculator pops with a valid/pop handshake. Sits between the `gpio_in[9:0]` pads and the calculator's input decode; it is the input-side counterpart of the display/LED output path.

---
 rtl/pb_key_decoder.sv | 122 ++++++++++++
 tb/tb_pb_key_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pb_key_decoder.sv
// Pushbutton front end: synchronizes and debounces ten raw buttons, turns each
// clean single-key press into a 4-bit code and queues it for the calculator.
module pb_key_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pb,
  input  logic       key_pop,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [2:0] key_count,
  output logic       multi_err,
  output logic       overflow
);

  localparam logic ST_STABLE   = 1'b0;
  localparam logic ST_SETTLING = 1'b1;

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic [9:0]  s1, s2, stable, cand;
  logic [15:0] cnt;
  logic        state;

  logic [9:0]  new_press;
  logic [3:0]  press_ones;
  logic [3:0]  press_idx;
  logic        commit;
  logic        push;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, do_push, drop;

  // Presses are bits that rise relative to the previously committed vector.
  always_comb begin
    new_press  = cand & ~stable;
    press_ones = '0;
    press_idx  = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (new_press[i]) begin
        press_ones = press_ones + 4'd1;
        press_idx  = 4'(i);
      end
    end
  end

  assign commit = (state == ST_SETTLING) && (s2 == cand) && (cnt == CNT_LAST);
  assign push   = commit && (press_ones == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      cand      <= '0;
      cnt       <= '0;
      state     <= ST_STABLE;
      multi_err <= 1'b0;
    end else begin
      s1        <= pb;
      s2        <= s1;
      multi_err <= commit && (press_ones > 4'd1);
      if (state == ST_STABLE) begin
        if (s2 != stable) begin
          cand  <= s2;
          cnt   <= '0;
          state <= ST_SETTLING;
        end
      end else begin
        if (s2 != cand) begin
          cand <= s2;
          cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= cand;
          state  <= ST_STABLE;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == COUNT_FULL);
  assign pop     = key_pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full queue survives.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= press_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (pop && !do_push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign key_valid = !empty;
  assign key_code  = empty ? 4'd0 : mem[rd_ptr];
  assign key_count = 3'(count);

endmodule

// File: tb/tb_pb_key_decoder.sv
// Directed bench for pb_key_decoder (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4) with
// hand-computed expected values.
module tb_pb_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pb;
  logic       key_pop;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] key_count;
  logic       multi_err;
  logic       overflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  pb_key_decoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .key_pop   (key_pop),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_count (key_count),
    .multi_err (multi_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"},  key_code,  0);
    check({tag, "_count"}, key_count, 0);
    check({tag, "_merr"},  multi_err, 0);
    check({tag, "_ovf"},   overflow,  0);
  endtask

  task automatic press_release(input int unsigned k);
    pb = 10'(1 << k);
    tick(8);
    pb = '0;
    tick(8);
  endtask

  int unsigned exp4 [4] = '{0, 1, 2, 3};
  int unsigned exp5 [4] = '{1, 2, 3, 6};

  initial begin
    rst = 1'b1; pb = '0; key_pop = 1'b0;
    tick(3);
    rst = 1'b0;
    check_zero("reset");

    // 1: single press of key 3, valid exactly after edge 6
    pb = 10'b00_0000_1000;
    tick(6);
    check("t1_early_valid", key_valid, 0);
    tick(1);
    check("t1_valid", key_valid, 1);
    check("t1_code",  key_code,  3);
    check("t1_count", key_count, 1);
    key_pop = 1'b1;
    tick(1);
    key_pop = 1'b0;
    check("t1_pop_valid", key_valid, 0);
    pb = '0;
    tick(10);
    check("t1_release_count", key_count, 0);

    // 2: bounce on key 5; last toggle sampled at e4, commit at e10
    pb = 10'h020; tick(1);
    pb = 10'h000; tick(1);
    pb = 10'h020; tick(1);
    pb = 10'h000; tick(1);
    pb = 10'h020; tick(1);
    tick(5);
    check("t2_early_valid", key_valid, 0);
    tick(1);
    check("t2_valid", key_valid, 1);
    check("t2_code",  key_code,  5);
    check("t2_count", key_count, 1);
    key_pop = 1'b1; tick(1); key_pop = 1'b0;
    pb = '0;
    tick(10);
    check("t2_release_count", key_count, 0);
    pb = 10'h080; tick(2);
    pb = 10'h000; tick(12);
    check("t2_glitch_count", key_count, 0);
    check("t2_glitch_valid", key_valid, 0);

    // 3: keys 1 and 2 together
    pb = 10'h006;
    tick(6);
    check("t3_merr_before", multi_err, 0);
    tick(1);
    check("t3_merr_pulse", multi_err, 1);
    check("t3_count", key_count, 0);
    tick(1);
    check("t3_merr_after", multi_err, 0);
    pb = 10'h002;
    tick(10);
    check("t3_release2_count", key_count, 0);
    pb = 10'h012;
    tick(7);
    check("t3_hold_valid", key_valid, 1);
    check("t3_hold_code",  key_code,  4);
    check("t3_hold_count", key_count, 1);
    key_pop = 1'b1; tick(1); key_pop = 1'b0;
    pb = '0;
    tick(10);

    // 4: fill and overflow, then back-to-back drain
    press_release(0);
    press_release(1);
    press_release(2);
    press_release(3);
    check("t4_full_ovf", overflow, 0);
    press_release(9);
    check("t4_count", key_count, 4);
    check("t4_ovf",   overflow,  1);
    key_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_code", key_code, exp4[i]);
      tick(1);
    end
    key_pop = 1'b0;
    check("t4_empty_valid", key_valid, 0);
    check("t4_empty_count", key_count, 0);
    check("t4_ovf_sticky",  overflow,  1);

    rst = 1'b1; tick(1); rst = 1'b0;
    check_zero("t4_reset");

    // 5: pop on the same edge key 6 commits into a full queue
    press_release(0);
    press_release(1);
    press_release(2);
    press_release(3);
    check("t5_count_full", key_count, 4);
    pb = 10'h040;
    tick(6);
    key_pop = 1'b1;
    tick(1);
    key_pop = 1'b0;
    check("t5_count", key_count, 4);
    check("t5_ovf",   overflow,  0);
    key_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_code", key_code, exp5[i]);
      tick(1);
    end
    key_pop = 1'b0;
    check("t5_empty_valid", key_valid, 0);
    pb = '0;
    tick(10);

    // 6: reset while settling with two queued entries
    press_release(7);
    press_release(8);
    check("t6_count_before", key_count, 2);
    pb = 10'h200;
    tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_zero("t6_reset");
    tick(6);
    check("t6_early_valid", key_valid, 0);
    tick(1);
    check("t6_valid", key_valid, 1);
    check("t6_code",  key_code,  9);
    check("t6_count", key_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
